legv8_instr_encoder: RTL and testbench
======================================

# legv8_instr_encoder

Streaming LEGv8 instruction encoder and instruction-memory loader: accepts decoded instruction descriptors (operation, register numbers, immediate) over a valid/ready stream, packs each into a 32-bit machine word and writes it to consecutive instruction-memory addresses. It is the encode-side counterpart of the pipeline's immediate sign-extension/decode logic. Every immediate it writes decodes back to the same 64-bit value in the pipeline. It sits between the host/test loader and the instruction memory write port.

## Interface

- `INSTR_WIDTH`, 32, machine word width
- `DATA_WIDTH`, 64, immediate width, same as the pipeline datapath
- `ADDR_WIDTH`, 9, instruction-memory word address width
- `clk` in 1: single clock
- `reset` in 1: synchronous, active-high
- `load_start` in 1: pulse; (re)starts a load at `start_addr`
- `start_addr` in ADDR_WIDTH: first word address
- `in_valid` in 1: descriptor valid
- `in_ready` out 1: descriptor accepted when `in_valid && in_ready`
- `in_last` in 1: marks final descriptor of a program
- `in_op` in 4: 0 ADD, 1 SUB, 2 AND, 3 ORR, 4 ADDI, 5 SUBI, 6 LDUR, 7 STUR, 8 B, 9 CBZ, 10 CBNZ; 11–15 illegal
- `in_rd`, `in_rn`, `in_rm` in 5 each: Rd/Rt, Rn, Rm
- `in_imm` in DATA_WIDTH: signed immediate; for branches a byte offset
- `imem_we` out 1, `imem_addr` out ADDR_WIDTH, `imem_wdata` out INSTR_WIDTH: memory write port
- `done` out 1: program fully written
- `err` out 1, `err_code` out 3: sticky error; 0 none, 1 illegal op, 2 immediate range, 3 misaligned branch, 4 memory full
- `count` out ADDR_WIDTH+1: words written since `load_start`

## Operation

- FSM states: IDLE, LOAD, DONE, ERROR.
  - Reset goes to IDLE.
  - `load_start` in any state goes to LOAD. It sets the write pointer to `start_addr` and clears `count`, `done`, `err` and `err_code`.
- `in_ready = (state==LOAD) && !load_start`. A beat presented in the same cycle as `load_start` is not accepted.
- Encoding. Unused fields are 0.
  - R-type: [31:21] = 10001011000 (ADD), 11001011000 (SUB), 10001010000 (AND), 10101010000 (ORR); Rm [20:16]; shamt [15:10] = 0; Rn [9:5]; Rd [4:0]. `in_imm` is ignored.
  - ADDI/SUBI: [31:21] = 10010001000 / 11010001000; imm12 [21:10] overlays bit 21. The legal range is 0..2047, so bit 21 stays 0.
  - LDUR/STUR: [31:21] = 11111000010 / 11111000000; imm9 [20:12] legal range −256..255; [11:10] = 00; Rn; Rt.
  - B: [31:26] = 000101; imm26 = offset>>>2. Offset must be a multiple of 4 and lie in −2^27..2^27−4.
  - CBZ/CBNZ: [31:24] = 10110100 / 10110101; imm19 [23:5] = offset>>>2; Rt [4:0]. Offset must be a multiple of 4 and lie in −2^20..2^20−4.
- Range checks use the full `in_imm` value. Upper bits must be a proper sign extension.
- Error check priority: illegal op, then misaligned, then range, then full.
- An erroring beat:
  - is consumed, but no write occurs;
  - sets `err`/`err_code`;
  - moves the FSM to ERROR.
- Full: after the write at address 2^ADDR_WIDTH−1, the pointer is flagged full. The next accepted beat errors with code 4. No wrap-around.
- An accepted `in_last` beat without error moves the FSM to DONE.
- `done` and `err` hold until `load_start` or `reset`.

## Timing

- Accept in cycle N; `imem_we`, `imem_addr` and `imem_wdata` are registered and valid in cycle N+1 for exactly one cycle. `count` increments in N+1.
- Throughput is one word per cycle with back-to-back beats. There is no backpressure from memory.
- `done`/`err` assert in cycle N+1 relative to the final or erroring beat. `in_ready` falls in N+1.
- Reset values: `in_ready` 0, `imem_we` 0, `imem_addr` 0, `imem_wdata` 0, `done` 0, `err` 0, `err_code` 0, `count` 0.
- Reset mid-LOAD: all outputs at reset value next cycle. A pending write is dropped.
- `load_start` mid-LOAD: a write registered in the previous cycle still completes. The next write goes to `start_addr`.

## Structure

- Shared package `legv8_pkg`: 11-bit R/I/D opcode constants, 6-bit B opcode, 8-bit CBZ/CBNZ opcodes, `in_op` enum, `err_code` constants, immediate range limits. The pipeline's decode/sign-extension logic uses the same constants.
- Sub-module `legv8_encode`: combinational descriptor to {word, err_code} encoder with legality checks.
- The top level holds the FSM, pointer, counter and output registers.

## Test plan

- ADD rd=1 rn=2 rm=3 at `start_addr`=0 → `imem_wdata`=0x8B030041 at addr 0; ADDI rd=1 rn=2 imm=5 → 0x91001441 at addr 1.
- LDUR rt=3 rn=4 imm=−8 → 0xF85F8083. Feeding this word through the pipeline's sign-extender yields 0xFFFF_FFFF_FFFF_FFF8.
- B offset −4 → 0x17FFFFFF; CBZ rt=0 offset 8 → 0xB4000040; CBNZ rt=5 offset −8 → 0xB5FFFFC5.
- ADDI imm=2048 → no write, `err`=1, code 2. After `load_start`, LDUR imm=256 → code 2. B offset 6 → code 3. `in_op`=12 → code 1.
- Four back-to-back beats with `in_last` on the fourth → writes at addr 0–3 on consecutive cycles; `done`=1 and `count`=4 one cycle after the last accept.
- `ADDR_WIDTH`=2, `start_addr`=3, two beats → first written at 3, second gives code 4. Reset asserted mid-LOAD → all outputs 0 next cycle.

Source files
------------

// File: rtl/legv8_pkg.sv
// Shared LEGv8 encoding constants: opcodes, op/state enums, error codes, immediate limits.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package legv8_pkg;

    // R/I/D-format 11-bit opcodes, placed in [31:21]
    localparam logic [10:0] OPC_ADD  = 11'b10001011000;
    localparam logic [10:0] OPC_SUB  = 11'b11001011000;
    localparam logic [10:0] OPC_AND  = 11'b10001010000;
    localparam logic [10:0] OPC_ORR  = 11'b10101010000;
    localparam logic [10:0] OPC_ADDI = 11'b10010001000;
    localparam logic [10:0] OPC_SUBI = 11'b11010001000;
    localparam logic [10:0] OPC_LDUR = 11'b11111000010;
    localparam logic [10:0] OPC_STUR = 11'b11111000000;

    // B-format 6-bit opcode [31:26], CB-format 8-bit opcodes [31:24]
    localparam logic [5:0]  OPC_B    = 6'b000101;
    localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
    localparam logic [7:0]  OPC_CBNZ = 8'b10110101;

    // Descriptor operation codes; 11..15 are illegal
    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_ORR  = 4'd3,
        OP_ADDI = 4'd4,
        OP_SUBI = 4'd5,
        OP_LDUR = 4'd6,
        OP_STUR = 4'd7,
        OP_B    = 4'd8,
        OP_CBZ  = 4'd9,
        OP_CBNZ = 4'd10
    } op_e;

    // Sticky error codes
    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_ILLEGAL  = 3'd1;
    localparam logic [2:0] ERR_RANGE    = 3'd2;
    localparam logic [2:0] ERR_MISALIGN = 3'd3;
    localparam logic [2:0] ERR_FULL     = 3'd4;

    // Immediate limits: unsigned imm12, signed imm9, byte offsets for B and CB
    localparam longint IMM12_MIN = 0;
    localparam longint IMM12_MAX = 2047;
    localparam longint IMM9_MIN  = -256;
    localparam longint IMM9_MAX  = 255;
    localparam longint BR26_MIN  = -134217728;
    localparam longint BR26_MAX  = 134217724;
    localparam longint CB19_MIN  = -1048576;
    localparam longint CB19_MAX  = 1048572;

    // Loader FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERROR = 2'd3
    } state_e;

    // D-format immediate sign extension, as done by the pipeline decoder
    function automatic logic [63:0] dtype_imm_sext(input logic [31:0] w);
        return {{55{w[20]}}, w[20:12]};
    endfunction

endpackage

// File: rtl/legv8_instr_encoder_if.sv
// Descriptor stream plus instruction-memory write port of the encoder/loader.
// Latency: n/a (wires only).
// Backpressure: in_ready is driven by the slave; the memory side has none.
interface legv8_instr_encoder_if #(
    parameter int INSTR_WIDTH = 32,
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 9
);
    logic                   load_start;
    logic [ADDR_WIDTH-1:0]  start_addr;
    logic                   in_valid;
    logic                   in_ready;
    logic                   in_last;
    logic [3:0]             in_op;
    logic [4:0]             in_rd;
    logic [4:0]             in_rn;
    logic [4:0]             in_rm;
    logic [DATA_WIDTH-1:0]  in_imm;
    logic                   imem_we;
    logic [ADDR_WIDTH-1:0]  imem_addr;
    logic [INSTR_WIDTH-1:0] imem_wdata;
    logic                   done;
    logic                   err;
    logic [2:0]             err_code;
    logic [ADDR_WIDTH:0]    count;

    modport master (
        output load_start, start_addr, in_valid, in_last, in_op, in_rd, in_rn, in_rm, in_imm,
        input  in_ready, imem_we, imem_addr, imem_wdata, done, err, err_code, count
    );

    modport slave (
        input  load_start, start_addr, in_valid, in_last, in_op, in_rd, in_rn, in_rm, in_imm,
        output in_ready, imem_we, imem_addr, imem_wdata, done, err, err_code, count
    );
endinterface

// File: rtl/legv8_encode.sv
// Packs one decoded descriptor into a 32-bit LEGv8 word and reports legality.
// Latency: combinational.
// Backpressure: none; the caller decides whether to use the result.
module legv8_encode
    import legv8_pkg::*;
#(
    parameter int INSTR_WIDTH = 32,
    parameter int DATA_WIDTH  = 64
) (
    input  logic [3:0]             i_op,
    input  logic [4:0]             i_rd,
    input  logic [4:0]             i_rn,
    input  logic [4:0]             i_rm,
    input  logic [DATA_WIDTH-1:0]  i_imm,
    output logic [INSTR_WIDTH-1:0] o_word,
    output logic [2:0]             o_err_code
);

    // Full-width signed view so out-of-range upper bits are caught, not truncated
    logic signed [DATA_WIDTH-1:0] w_simm;
    logic                         w_misaligned;

    assign w_simm       = $signed(i_imm);
    assign w_misaligned = (i_imm[1:0] != 2'b00);

    // Format selection with checks in priority order: illegal, misaligned, range
    always_comb begin
        o_word     = '0;
        o_err_code = ERR_NONE;
        case (i_op)
            OP_ADD:  o_word = {OPC_ADD, i_rm, 6'b0, i_rn, i_rd};
            OP_SUB:  o_word = {OPC_SUB, i_rm, 6'b0, i_rn, i_rd};
            OP_AND:  o_word = {OPC_AND, i_rm, 6'b0, i_rn, i_rd};
            OP_ORR:  o_word = {OPC_ORR, i_rm, 6'b0, i_rn, i_rd};
            OP_ADDI, OP_SUBI: begin
                // imm12 overlays opcode bit 21, which is 0 for both opcodes
                if (w_simm < IMM12_MIN || w_simm > IMM12_MAX) begin
                    o_err_code = ERR_RANGE;
                end else if (i_op == OP_ADDI) begin
                    o_word = {OPC_ADDI[10:1], i_imm[11:0], i_rn, i_rd};
                end else begin
                    o_word = {OPC_SUBI[10:1], i_imm[11:0], i_rn, i_rd};
                end
            end
            OP_LDUR, OP_STUR: begin
                if (w_simm < IMM9_MIN || w_simm > IMM9_MAX) begin
                    o_err_code = ERR_RANGE;
                end else if (i_op == OP_LDUR) begin
                    o_word = {OPC_LDUR, i_imm[8:0], 2'b00, i_rn, i_rd};
                end else begin
                    o_word = {OPC_STUR, i_imm[8:0], 2'b00, i_rn, i_rd};
                end
            end
            OP_B: begin
                if (w_misaligned) begin
                    o_err_code = ERR_MISALIGN;
                end else if (w_simm < BR26_MIN || w_simm > BR26_MAX) begin
                    o_err_code = ERR_RANGE;
                end else begin
                    o_word = {OPC_B, i_imm[27:2]};
                end
            end
            OP_CBZ, OP_CBNZ: begin
                if (w_misaligned) begin
                    o_err_code = ERR_MISALIGN;
                end else if (w_simm < CB19_MIN || w_simm > CB19_MAX) begin
                    o_err_code = ERR_RANGE;
                end else if (i_op == OP_CBZ) begin
                    o_word = {OPC_CBZ, i_imm[20:2], i_rd};
                end else begin
                    o_word = {OPC_CBNZ, i_imm[20:2], i_rd};
                end
            end
            default: o_err_code = ERR_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/legv8_instr_encoder.sv
// Streams descriptors into consecutive instruction-memory words with sticky error reporting.
// Latency: write port, count, done and err are registered, valid one cycle after accept.
// Backpressure: in_ready only in LOAD and not during load_start; memory never stalls.
module legv8_instr_encoder
    import legv8_pkg::*;
#(
    parameter int INSTR_WIDTH = 32,
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 9
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    legv8_instr_encoder_if.slave  bus
);

    logic [INSTR_WIDTH-1:0] w_word;
    logic [2:0]             w_enc_code;
    logic                   w_in_ready;
    logic                   w_accept;
    logic                   w_bad;

    state_e                 r_state;
    logic [ADDR_WIDTH-1:0]  r_ptr;
    logic                   r_full;
    logic [ADDR_WIDTH:0]    r_count;
    logic                   r_we;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [INSTR_WIDTH-1:0] r_wdata;
    logic                   r_done;
    logic                   r_err;
    logic [2:0]             r_err_code;

    legv8_encode #(
        .INSTR_WIDTH (INSTR_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH)
    ) u_encode (
        .i_op       (bus.in_op),
        .i_rd       (bus.in_rd),
        .i_rn       (bus.in_rn),
        .i_rm       (bus.in_rm),
        .i_imm      (bus.in_imm),
        .o_word     (w_word),
        .o_err_code (w_enc_code)
    );

    // A beat arriving alongside load_start belongs to no program and is refused
    assign w_in_ready = (r_state == ST_LOAD) && !bus.load_start;
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_bad      = (w_enc_code != ERR_NONE) || r_full;

    // Loader FSM, write pointer, word counter and registered memory port
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_full     <= 1'b0;
            r_count    <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
        end else begin
            r_we <= 1'b0;
            if (bus.load_start) begin
                r_state    <= ST_LOAD;
                r_ptr      <= bus.start_addr;
                r_full     <= 1'b0;
                r_count    <= '0;
                r_done     <= 1'b0;
                r_err      <= 1'b0;
                r_err_code <= ERR_NONE;
            end else if (w_accept) begin
                if (w_bad) begin
                    // Encoder faults outrank the full condition
                    r_err      <= 1'b1;
                    r_err_code <= (w_enc_code != ERR_NONE) ? w_enc_code : ERR_FULL;
                    r_state    <= ST_ERROR;
                end else begin
                    r_we    <= 1'b1;
                    r_addr  <= r_ptr;
                    r_wdata <= w_word;
                    r_count <= r_count + 1'b1;
                    // Top address reached: flag full instead of wrapping
                    if (r_ptr == '1) begin
                        r_full <= 1'b1;
                    end else begin
                        r_ptr <= r_ptr + 1'b1;
                    end
                    if (bus.in_last) begin
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
            end
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.imem_we    = r_we;
    assign bus.imem_addr  = r_addr;
    assign bus.imem_wdata = r_wdata;
    assign bus.done       = r_done;
    assign bus.err        = r_err;
    assign bus.err_code   = r_err_code;
    assign bus.count      = r_count;

endmodule

// File: tb/tb_legv8_instr_encoder.sv
// Scoreboard bench: stimulus pushes expected writes, a negedge monitor pops and compares.
// Two instances: a 512-word memory for encoding/flow, a 4-word memory for the full case.
// Status outputs (done/err/count/in_ready) are checked directly after each accept.
module tb_legv8_instr_encoder;
    import legv8_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [8:0]  addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        q_a[$];
    exp_t        q_b[$];
    logic [31:0] mem_a [0:511];
    logic [8:0]  ptr_a = '0;
    logic [1:0]  ptr_b = '0;

    legv8_instr_encoder_if #(.INSTR_WIDTH(32), .DATA_WIDTH(64), .ADDR_WIDTH(9)) bus_a ();
    legv8_instr_encoder_if #(.INSTR_WIDTH(32), .DATA_WIDTH(64), .ADDR_WIDTH(2)) bus_b ();

    legv8_instr_encoder #(.INSTR_WIDTH(32), .DATA_WIDTH(64), .ADDR_WIDTH(9)) u_dut_a (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus_a)
    );

    legv8_instr_encoder #(.INSTR_WIDTH(32), .DATA_WIDTH(64), .ADDR_WIDTH(2)) u_dut_b (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus_b)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every memory write must match the head of its expected queue, in the right cycle
    always @(negedge clk) begin
        if (bus_a.imem_we === 1'b1) begin
            if (q_a.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL a_unexpected_write: got addr 0x%0h data 0x%0h, required no write",
                         bus_a.imem_addr, bus_a.imem_wdata);
            end else begin
                exp_t e;
                e = q_a.pop_front();
                chk("a_addr",  64'(bus_a.imem_addr),  64'(e.addr));
                chk("a_data",  64'(bus_a.imem_wdata), 64'(e.data));
                chk("a_cycle", 64'(cyc),              64'(e.cyc));
                mem_a[bus_a.imem_addr] = bus_a.imem_wdata;
            end
        end
        if (bus_b.imem_we === 1'b1) begin
            if (q_b.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL b_unexpected_write: got addr 0x%0h data 0x%0h, required no write",
                         bus_b.imem_addr, bus_b.imem_wdata);
            end else begin
                exp_t e;
                e = q_b.pop_front();
                chk("b_addr",  64'(bus_b.imem_addr),  64'(e.addr));
                chk("b_data",  64'(bus_b.imem_wdata), 64'(e.data));
                chk("b_cycle", 64'(cyc),              64'(e.cyc));
            end
        end
    end

    // Called at a negedge; returns at the negedge one cycle after the load_start edge
    task automatic start_a(input logic [8:0] a);
        bus_a.load_start = 1'b1;
        bus_a.start_addr = a;
        @(negedge clk);
        bus_a.load_start = 1'b0;
        ptr_a = a;
    endtask

    task automatic start_b(input logic [1:0] a);
        bus_b.load_start = 1'b1;
        bus_b.start_addr = a;
        @(negedge clk);
        bus_b.load_start = 1'b0;
        ptr_b = a;
    endtask

    // Present one beat at a negedge, wait (bounded) for ready, return at the negedge after accept
    task automatic issue_a(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rn,
                           input logic [4:0] rm, input logic [63:0] imm, input logic last,
                           input logic wr, input logic [31:0] word);
        int   t = 0;
        exp_t e;
        bus_a.in_op    = op;
        bus_a.in_rd    = rd;
        bus_a.in_rn    = rn;
        bus_a.in_rm    = rm;
        bus_a.in_imm   = imm;
        bus_a.in_last  = last;
        bus_a.in_valid = 1'b1;
        #1;
        while (bus_a.in_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (t >= 20) begin
            n_chk++;
            n_fail++;
            $display("FAIL a_ready_timeout: got in_ready=0 for 20 cycles, required 1");
        end
        if (wr) begin
            e.addr = ptr_a;
            e.data = word;
            e.cyc  = cyc + 1;
            q_a.push_back(e);
            ptr_a++;
        end
        @(posedge clk);
        @(negedge clk);
        bus_a.in_valid = 1'b0;
        bus_a.in_last  = 1'b0;
    endtask

    task automatic issue_b(input logic [3:0] op, input logic [63:0] imm,
                           input logic wr, input logic [31:0] word);
        int   t = 0;
        exp_t e;
        bus_b.in_op    = op;
        bus_b.in_rd    = 5'd1;
        bus_b.in_rn    = 5'd2;
        bus_b.in_rm    = 5'd3;
        bus_b.in_imm   = imm;
        bus_b.in_last  = 1'b0;
        bus_b.in_valid = 1'b1;
        #1;
        while (bus_b.in_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (t >= 20) begin
            n_chk++;
            n_fail++;
            $display("FAIL b_ready_timeout: got in_ready=0 for 20 cycles, required 1");
        end
        if (wr) begin
            e.addr = {7'd0, ptr_b};
            e.data = word;
            e.cyc  = cyc + 1;
            q_b.push_back(e);
            ptr_b++;
        end
        @(posedge clk);
        @(negedge clk);
        bus_b.in_valid = 1'b0;
    endtask

    // One erroring beat in a fresh load: no write, sticky err with the given code
    task automatic err_case_a(input string name, input logic [3:0] op, input logic [63:0] imm,
                              input logic [2:0] code);
        start_a(9'd100);
        issue_a(op, 5'd1, 5'd2, 5'd3, imm, 1'b0, 1'b0, 32'd0);
        chk({name, "_err"},      64'(bus_a.err),      64'd1);
        chk({name, "_code"},     64'(bus_a.err_code), 64'(code));
        chk({name, "_count"},    64'(bus_a.count),    64'd0);
        chk({name, "_in_ready"}, 64'(bus_a.in_ready), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_a.load_start = 1'b0; bus_a.start_addr = '0; bus_a.in_valid = 1'b0; bus_a.in_last = 1'b0;
        bus_a.in_op = '0; bus_a.in_rd = '0; bus_a.in_rn = '0; bus_a.in_rm = '0; bus_a.in_imm = '0;
        bus_b.load_start = 1'b0; bus_b.start_addr = '0; bus_b.in_valid = 1'b0; bus_b.in_last = 1'b0;
        bus_b.in_op = '0; bus_b.in_rd = '0; bus_b.in_rn = '0; bus_b.in_rm = '0; bus_b.in_imm = '0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(bus_a.in_ready),   64'd0);
        chk("rst_we",       64'(bus_a.imem_we),    64'd0);
        chk("rst_addr",     64'(bus_a.imem_addr),  64'd0);
        chk("rst_wdata",    64'(bus_a.imem_wdata), 64'd0);
        chk("rst_done",     64'(bus_a.done),       64'd0);
        chk("rst_err",      64'(bus_a.err),        64'd0);
        chk("rst_code",     64'(bus_a.err_code),   64'd0);
        chk("rst_count",    64'(bus_a.count),      64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", 64'(bus_a.in_ready), 64'd0);

        // Program 1: every format plus immediate boundaries, back to back from address 0
        start_a(9'd0);
        issue_a(OP_ADD,  5'd1, 5'd2, 5'd3, 64'd0,                  1'b0, 1'b1, 32'h8B030041);
        issue_a(OP_ADDI, 5'd1, 5'd2, 5'd0, 64'd5,                  1'b0, 1'b1, 32'h91001441);
        issue_a(OP_LDUR, 5'd3, 5'd4, 5'd0, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 1'b1, 32'hF85F8083);
        issue_a(OP_B,    5'd0, 5'd0, 5'd0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b1, 32'h17FFFFFF);
        issue_a(OP_CBZ,  5'd0, 5'd0, 5'd0, 64'd8,                  1'b0, 1'b1, 32'hB4000040);
        issue_a(OP_SUBI, 5'd0, 5'd0, 5'd0, 64'd2047,               1'b0, 1'b1, 32'hD11FFC00);
        issue_a(OP_LDUR, 5'd1, 5'd1, 5'd0, 64'hFFFF_FFFF_FFFF_FF00, 1'b0, 1'b1, 32'hF8500021);
        issue_a(OP_CBZ,  5'd1, 5'd0, 5'd0, 64'd1048572,            1'b0, 1'b1, 32'hB47FFFE1);
        issue_a(OP_B,    5'd0, 5'd0, 5'd0, 64'hFFFF_FFFF_F800_0000, 1'b0, 1'b1, 32'h16000000);
        issue_a(OP_B,    5'd0, 5'd0, 5'd0, 64'd134217724,          1'b0, 1'b1, 32'h15FFFFFF);
        issue_a(OP_CBNZ, 5'd5, 5'd0, 5'd0, 64'hFFFF_FFFF_FFFF_FFF8, 1'b1, 1'b1, 32'hB5FFFFC5);
        chk("p1_done",     64'(bus_a.done),     64'd1);
        chk("p1_count",    64'(bus_a.count),    64'd11);
        chk("p1_in_ready", 64'(bus_a.in_ready), 64'd0);
        repeat (3) @(negedge clk);
        chk("p1_done_hold", 64'(bus_a.done), 64'd1);
        chk("ldur_sext", dtype_imm_sext(mem_a[2]), 64'hFFFF_FFFF_FFFF_FFF8);

        // Program 2: four back-to-back beats, last on the fourth
        start_a(9'd0);
        chk("p2_done_cleared", 64'(bus_a.done), 64'd0);
        issue_a(OP_SUB,  5'd4,  5'd5, 5'd6,  64'd0,   1'b0, 1'b1, 32'hCB0600A4);
        issue_a(OP_AND,  5'd7,  5'd8, 5'd9,  64'd0,   1'b0, 1'b1, 32'h8A090107);
        issue_a(OP_ORR,  5'd31, 5'd0, 5'd31, 64'd0,   1'b0, 1'b1, 32'hAA1F001F);
        issue_a(OP_STUR, 5'd2,  5'd1, 5'd0,  64'd255, 1'b1, 1'b1, 32'hF80FF022);
        chk("p2_done",  64'(bus_a.done),  64'd1);
        chk("p2_count", 64'(bus_a.count), 64'd4);

        // Error cases, each in its own load
        err_case_a("addi_2048",   OP_ADDI, 64'd2048,                3'd2);
        repeat (2) @(negedge clk);
        chk("err_sticky", 64'(bus_a.err), 64'd1);
        err_case_a("ldur_256",    OP_LDUR, 64'd256,                 3'd2);
        err_case_a("b_off6",      OP_B,    64'd6,                   3'd3);
        err_case_a("b_mis_range", OP_B,    64'd134217730,           3'd3);
        err_case_a("op12",        4'd12,   64'd0,                   3'd1);
        err_case_a("cbz_2p20",    OP_CBZ,  64'd1048576,             3'd2);
        err_case_a("addi_hi",     OP_ADDI, 64'h0000_0001_0000_0005, 3'd2);
        err_case_a("ldur_nosext", OP_LDUR, 64'h0000_0000_FFFF_FFF8, 3'd2);

        // load_start mid-LOAD: prior write completes, concurrent beat refused, restart at new address
        start_a(9'd32);
        issue_a(OP_ADD, 5'd1, 5'd2, 5'd3, 64'd0, 1'b0, 1'b1, 32'h8B030041);
        bus_a.load_start = 1'b1;
        bus_a.start_addr = 9'd40;
        bus_a.in_op      = OP_ADDI;
        bus_a.in_imm     = 64'd5;
        bus_a.in_valid   = 1'b1;
        #1;
        chk("ls_in_ready", 64'(bus_a.in_ready), 64'd0);
        @(negedge clk);
        bus_a.load_start = 1'b0;
        ptr_a = 9'd40;
        issue_a(OP_ADDI, 5'd1, 5'd2, 5'd0, 64'd5, 1'b0, 1'b1, 32'h91001441);
        chk("ls_count", 64'(bus_a.count), 64'd1);

        // Reset mid-LOAD with a beat in flight: all outputs return to reset values
        issue_a(OP_ADD, 5'd1, 5'd2, 5'd3, 64'd0, 1'b0, 1'b1, 32'h8B030041);
        bus_a.in_op    = OP_ADD;
        bus_a.in_valid = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        bus_a.in_valid = 1'b0;
        chk("mrst_in_ready", 64'(bus_a.in_ready),   64'd0);
        chk("mrst_we",       64'(bus_a.imem_we),    64'd0);
        chk("mrst_addr",     64'(bus_a.imem_addr),  64'd0);
        chk("mrst_wdata",    64'(bus_a.imem_wdata), 64'd0);
        chk("mrst_done",     64'(bus_a.done),       64'd0);
        chk("mrst_err",      64'(bus_a.err),        64'd0);
        chk("mrst_code",     64'(bus_a.err_code),   64'd0);
        chk("mrst_count",    64'(bus_a.count),      64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Small memory: write at the top address, next beat reports full
        start_b(2'd3);
        issue_b(OP_ADD, 64'd0, 1'b1, 32'h8B030041);
        issue_b(OP_ADD, 64'd0, 1'b0, 32'd0);
        chk("full_err",      64'(bus_b.err),      64'd1);
        chk("full_code",     64'(bus_b.err_code), 64'd4);
        chk("full_count",    64'(bus_b.count),    64'd1);
        chk("full_in_ready", 64'(bus_b.in_ready), 64'd0);

        repeat (3) @(negedge clk);
        chk("q_a_drained", 64'(q_a.size()), 64'd0);
        chk("q_b_drained", 64'(q_b.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
